// File: rtl/key_press_ctrl_pkg.sv
// Shared definitions for the key press controller: state encoding,
// time-base constants and a small elaboration-time helper.
package key_press_ctrl_pkg;

   // Milliseconds per second; converts a clock frequency into cycles per ms.
   localparam int MS_PER_SEC = 1000;

   // State encoding of the press-classification FSM.
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_PRESSED   = 2'd1;
   localparam logic [1:0] ST_LONG_HELD = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      PRESSED   = ST_PRESSED,
      LONG_HELD = ST_LONG_HELD
   } kp_state_t;

   // Larger of two integers, used to size the ms counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_press_ctrl_ms_tick_gen.sv
// Millisecond tick divider. Counts 0..DIV-1 while enabled and raises tick
// in the cycle before the wrap, so a consumer that samples tick on the
// next edge sees the k-th tick exactly at edge k*DIV-1 after a clear.
// The owner then registers its reaction, landing pulses on edge k*DIV.
module ms_tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

   logic [CW-1:0] cnt_reg;

   // Divider counter: cleared on reset/clr, free-running modulo DIV when enabled.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg <= '0;
      end else if (en) begin
         if (cnt_reg == LAST) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign tick = en && !clr && (cnt_reg == PRE);

endmodule

// File: rtl/key_press_ctrl.sv
// Key press classifier: turns debounced key edges into short, long and
// auto-repeat pulses. Events are decided on the edge where the release or
// threshold is sampled and presented one cycle later through output
// registers, so every pulse and key_held come straight from flops.
module key_press_ctrl
   import key_press_ctrl_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic button_out,
   input  logic button_negedge,
   input  logic button_posedge,
   output logic short_press,
   output logic long_press,
   output logic repeat_press,
   output logic key_held
);

   localparam int N      = CLK_FREQ_HZ / MS_PER_SEC;
   localparam int MS_MAX = max_int(LONG_MS, REPEAT_MS);
   localparam int MSW    = $clog2(MS_MAX + 1);

   // Thresholds compared one tick early: reaching the count and the event
   // happen on the same edge.
   localparam logic [MSW-1:0] LONG_LAST = MSW'(LONG_MS - 1);
   localparam logic [MSW-1:0] REP_LAST  = MSW'(REPEAT_MS - 1);

   kp_state_t        state_reg, state_next;
   logic [MSW-1:0]   ms_cnt_reg, ms_cnt_next;
   logic             ms_tick;
   logic             div_clr;
   logic             key_release;
   logic             short_evt, long_evt, rep_evt;
   logic             short_evt_reg, long_evt_reg, rep_evt_reg;
   logic             short_press_reg, long_press_reg, repeat_press_reg;
   logic             key_held_reg;

   ms_tick_gen #(
      .DIV (N)
   ) u_ms_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (div_clr),
      .en   (state_reg != IDLE),
      .tick (ms_tick)
   );

   // A release is either the debouncer's edge pulse or the level already high.
   assign key_release = button_posedge | button_out;

   // Next-state, ms counter and event decode; release beats any threshold.
   always_comb begin
      state_next  = state_reg;
      ms_cnt_next = ms_cnt_reg;
      short_evt   = 1'b0;
      long_evt    = 1'b0;
      rep_evt     = 1'b0;
      div_clr     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (button_negedge) begin
               state_next  = PRESSED;
               ms_cnt_next = '0;
               div_clr     = 1'b1;
            end
         end
         PRESSED: begin
            if (key_release) begin
               state_next  = IDLE;
               ms_cnt_next = '0;
               short_evt   = 1'b1;
            end else if (ms_tick) begin
               if (ms_cnt_reg == LONG_LAST) begin
                  state_next  = LONG_HELD;
                  ms_cnt_next = '0;
                  long_evt    = 1'b1;
               end else begin
                  ms_cnt_next = ms_cnt_reg + MSW'(1);
               end
            end
         end
         LONG_HELD: begin
            if (key_release) begin
               state_next  = IDLE;
               ms_cnt_next = '0;
            end else if (ms_tick) begin
               if (ms_cnt_reg == REP_LAST) begin
                  ms_cnt_next = '0;
                  rep_evt     = 1'b1;
               end else begin
                  ms_cnt_next = ms_cnt_reg + MSW'(1);
               end
            end
         end
         default: begin
            state_next  = IDLE;
            ms_cnt_next = '0;
         end
      endcase
   end

   // State and ms counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         ms_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         ms_cnt_reg <= ms_cnt_next;
      end
   end

   // Event capture followed by the output stage; reset drops any pending pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         short_evt_reg    <= 1'b0;
         long_evt_reg     <= 1'b0;
         rep_evt_reg      <= 1'b0;
         short_press_reg  <= 1'b0;
         long_press_reg   <= 1'b0;
         repeat_press_reg <= 1'b0;
         key_held_reg     <= 1'b0;
      end else begin
         short_evt_reg    <= short_evt;
         long_evt_reg     <= long_evt;
         rep_evt_reg      <= rep_evt;
         short_press_reg  <= short_evt_reg;
         long_press_reg   <= long_evt_reg;
         repeat_press_reg <= rep_evt_reg;
         key_held_reg     <= (state_reg != IDLE);
      end
   end

   assign short_press  = short_press_reg;
   assign long_press   = long_press_reg;
   assign repeat_press = repeat_press_reg;
   assign key_held     = key_held_reg;

endmodule

// File: tb/tb_key_press_ctrl.sv
// Scoreboard bench for key_press_ctrl with N=2, LONG_MS=10, REPEAT_MS=4.
// Stimulus pushes expected pulses and key_held levels tagged with the edge
// number they must appear on; the monitor pops and compares each cycle.
module tb_key_press_ctrl;

   localparam int K_SHORT = 0;
   localparam int K_LONG  = 1;
   localparam int K_REP   = 2;

   typedef struct {
      int kind;
      int cyc;
   } pulse_t;

   typedef struct {
      int cyc;
      bit val;
   } level_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic button_out = 1'b1;
   logic button_negedge = 1'b0;
   logic button_posedge = 1'b0;
   logic short_press, long_press, repeat_press, key_held;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   bit started = 1'b0;
   bit done = 1'b0;
   bit mon_done = 1'b0;

   pulse_t pulse_q[$];
   level_t level_q[$];

   key_press_ctrl #(
      .CLK_FREQ_HZ (2000),
      .LONG_MS     (10),
      .REPEAT_MS   (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .button_out     (button_out),
      .button_negedge (button_negedge),
      .button_posedge (button_posedge),
      .short_press    (short_press),
      .long_press     (long_press),
      .repeat_press   (repeat_press),
      .key_held       (key_held)
   );

   always #10 clk = ~clk;

   // Edge counter: after edge e, cyc == e.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares DUT outputs against the scoreboard queues.
   always @(negedge clk) begin
      if (started && !mon_done) begin
         int n;
         int kind;
         pulse_t p;
         level_t l;
         while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
            p = pulse_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse: kind=%0d expected at cycle %0d but it did not occur", p.kind, p.cyc);
         end
         n = int'(short_press === 1'b1) + int'(long_press === 1'b1) + int'(repeat_press === 1'b1);
         if (n > 1) begin
            total++;
            bad++;
            $display("FAIL pulse_exclusive: cycle %0d got %0d pulses, required at most 1", cyc, n);
         end
         if (n > 0) begin
            kind = (short_press === 1'b1) ? K_SHORT : ((long_press === 1'b1) ? K_LONG : K_REP);
            total++;
            if (pulse_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pulse: kind=%0d at cycle %0d, required none", kind, cyc);
            end else begin
               p = pulse_q.pop_front();
               if (p.kind != kind || p.cyc != cyc) begin
                  bad++;
                  $display("FAIL pulse: got kind=%0d cycle=%0d, required kind=%0d cycle=%0d", kind, cyc, p.kind, p.cyc);
               end else begin
                  $display("pulse ok: kind=%0d cycle=%0d", kind, cyc);
               end
            end
         end
         while (level_q.size() > 0 && level_q[0].cyc <= cyc) begin
            l = level_q.pop_front();
            total++;
            if (l.cyc != cyc || key_held !== l.val) begin
               bad++;
               $display("FAIL key_held: cycle %0d got %b, required %b at cycle %0d", cyc, key_held, l.val, l.cyc);
            end else begin
               $display("key_held ok: cycle=%0d val=%b", cyc, key_held);
            end
         end
         if (done) begin
            total++;
            if (pulse_q.size() != 0 || level_q.size() != 0) begin
               bad++;
               $display("FAIL drain: %0d pulses and %0d levels left, required 0", pulse_q.size(), level_q.size());
            end
            mon_done = 1'b1;
         end
      end
   end

   task automatic exp_pulse(input int kind, input int c);
      pulse_t p;
      p.kind = kind;
      p.cyc  = c;
      pulse_q.push_back(p);
   endtask

   task automatic exp_level(input int c, input bit v);
      level_t l;
      l.cyc = c;
      l.val = v;
      level_q.push_back(l);
   endtask

   // Advance (at negedges) so that inputs set now are sampled on edge e.
   task automatic goto_edge(input int e);
      while (cyc < e - 1) @(negedge clk);
   endtask

   task automatic press(input int e);
      goto_edge(e);
      button_negedge = 1'b1;
      button_out     = 1'b0;
      @(negedge clk);
      button_negedge = 1'b0;
   endtask

   task automatic release_key(input int e, input bit with_edge);
      goto_edge(e);
      button_out     = 1'b1;
      button_posedge = with_edge;
      @(negedge clk);
      button_posedge = 1'b0;
   endtask

   task automatic spur_neg(input int e);
      goto_edge(e);
      button_negedge = 1'b1;
      @(negedge clk);
      button_negedge = 1'b0;
   endtask

   task automatic spur_pos(input int e);
      goto_edge(e);
      button_posedge = 1'b1;
      @(negedge clk);
      button_posedge = 1'b0;
   endtask

   initial begin
      int b;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      started = 1'b1;
      exp_level(cyc + 1, 1'b0);

      // Short press: release on edge 9 -> short_press on edge 10.
      b = cyc + 5;
      exp_level(b + 9, 1'b1);
      exp_level(b + 10, 1'b0);
      exp_pulse(K_SHORT, b + 10);
      press(b);
      release_key(b + 9, 1'b1);
      goto_edge(b + 30);

      // Long press with repeats, release on edge 45.
      b = cyc + 5;
      exp_pulse(K_LONG, b + 20);
      exp_pulse(K_REP, b + 28);
      exp_pulse(K_REP, b + 36);
      exp_pulse(K_REP, b + 44);
      exp_level(b + 45, 1'b1);
      exp_level(b + 46, 1'b0);
      press(b);
      release_key(b + 45, 1'b1);
      goto_edge(b + 70);

      // Release coincides with the long threshold: short only.
      b = cyc + 5;
      exp_pulse(K_SHORT, b + 20);
      press(b);
      release_key(b + 19, 1'b1);
      goto_edge(b + 40);

      // Reset during LONG_HELD, key kept held afterwards.
      b = cyc + 5;
      exp_pulse(K_LONG, b + 20);
      exp_level(b + 24, 1'b1);
      exp_level(b + 25, 1'b0);
      exp_level(b + 60, 1'b0);
      exp_level(b + 124, 1'b0);
      press(b);
      goto_edge(b + 25);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      release_key(b + 126, 1'b1);
      goto_edge(b + 140);

      // Spurious edges: posedge in IDLE, negedges in PRESSED and LONG_HELD.
      b = cyc + 6;
      exp_pulse(K_LONG, b + 20);
      exp_pulse(K_REP, b + 28);
      exp_level(b + 30, 1'b1);
      exp_level(b + 31, 1'b0);
      spur_pos(b - 2);
      press(b);
      spur_neg(b + 7);
      spur_neg(b + 24);
      release_key(b + 30, 1'b1);
      goto_edge(b + 50);

      // Release seen only through the level, no posedge pulse.
      b = cyc + 5;
      exp_pulse(K_SHORT, b + 6);
      exp_level(b + 6, 1'b0);
      press(b);
      release_key(b + 5, 1'b0);
      goto_edge(b + 20);

      done = 1'b1;
      for (int i = 0; i < 5 && !mon_done; i++) @(negedge clk);
      if (!mon_done) begin
         total++;
         bad++;
         $display("FAIL monitor_drain: monitor did not finish, required finish within 5 cycles");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
